// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg -- shared definitions for the data-memory controller.
//   * load/store (and one non-memory) aluop codes
//   * bus size encodings (0=byte, 1=half, 2=word)
//   * controller FSM state enum
//   * small decode helpers used by dmem_ctrl and dmem_lane
package dmem_ctrl_pkg;

    localparam logic [7:0] ALUOP_ADD   = 8'h01;
    localparam logic [7:0] ALUOP_LD_B  = 8'h20;
    localparam logic [7:0] ALUOP_LD_H  = 8'h21;
    localparam logic [7:0] ALUOP_LD_W  = 8'h22;
    localparam logic [7:0] ALUOP_LD_BU = 8'h23;
    localparam logic [7:0] ALUOP_LD_HU = 8'h24;
    localparam logic [7:0] ALUOP_ST_B  = 8'h25;
    localparam logic [7:0] ALUOP_ST_H  = 8'h26;
    localparam logic [7:0] ALUOP_ST_W  = 8'h27;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } dmem_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == ALUOP_LD_B) || (op == ALUOP_LD_H) || (op == ALUOP_LD_W) ||
               (op == ALUOP_LD_BU) || (op == ALUOP_LD_HU);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == ALUOP_ST_B) || (op == ALUOP_ST_H) || (op == ALUOP_ST_W);
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            ALUOP_LD_B, ALUOP_LD_BU, ALUOP_ST_B: return SIZE_B;
            ALUOP_LD_H, ALUOP_LD_HU, ALUOP_ST_H: return SIZE_H;
            default:                             return SIZE_W;
        endcase
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
        case (op_size(op))
            SIZE_H:  return off[0];
            SIZE_W:  return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Clears the address bits below the access size.
    function automatic logic [31:0] align_addr(input logic [7:0] op, input logic [31:0] addr);
        case (op_size(op))
            SIZE_H:  return {addr[31:1], 1'b0};
            SIZE_W:  return {addr[31:2], 2'b00};
            default: return addr;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane -- combinational byte-lane logic for the data-memory controller.
//   op      in  8   latched load/store aluop
//   off     in  2   address bits [1:0]
//   sdata   in  32  store data (reg2)
//   rdata   in  32  word read from the bus
//   size    out 2   bus size encoding
//   wstrb   out 4   byte strobes for a store of this size/offset
//   wdata   out 32  store data replicated across lanes
//   ldata   out 32  selected and sign/zero-extended load result
module dmem_lane
    import dmem_ctrl_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        size    = op_size(op);
        shifted = rdata >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_B: begin
                wstrb = 4'b0001 << off;
                wdata = {4{sdata[7:0]}};
            end
            SIZE_H: begin
                wstrb = 4'b0011 << {off[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = sdata;
            end
        endcase

        case (op)
            ALUOP_LD_B:  ldata = {{24{byte_v[7]}}, byte_v};
            ALUOP_LD_BU: ldata = {24'h0, byte_v};
            ALUOP_LD_H:  ldata = {{16{half_v[15]}}, half_v};
            ALUOP_LD_HU: ldata = {16'h0, half_v};
            default:     ldata = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory access controller between execute and writeback.
// Accepts one instruction per cycle in IDLE; non-memory results pass through a
// single writeback register, loads/stores run a REQ/WAIT bus handshake.
// Optional macro: DMEM_ALIGN_CHECK_EN -- misaligned H/W accesses raise ale_o
// instead of going to the bus.
//   clk, rst (async, active-low)
//   ex_valid_i, aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i : execute side
//   ex_ready_o                                                    : accept this cycle
//   data_req_o, data_wr_o, data_size_o, data_wstrb_o,
//   data_addr_o, data_wdata_o                                     : bus request
//   data_addr_ok_i, data_data_ok_i, data_rdata_i                  : bus response
//   wb_valid_o, wd_o, wreg_o, wdata_o, ale_o                      : registered writeback
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    output logic        ex_ready_o,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        ale_o
);

    dmem_state_t state, state_nxt;

    logic [7:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [4:0]  wd_q;
    logic        wreg_q;

    logic        accept, mem_op, misal, take_mem, finish;
    logic [31:0] issue_addr;
    logic [1:0]  lane_size;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata, lane_ldata;

    assign mem_op = is_load(aluop_i) || is_store(aluop_i);
    assign accept = ex_valid_i && (state == S_IDLE);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misal      = mem_op && misaligned(aluop_i, mem_addr_i[1:0]);
    assign issue_addr = mem_addr_i;
`else
    // Without the check, misaligned accesses go out with the low bits dropped.
    assign misal      = 1'b0;
    assign issue_addr = align_addr(aluop_i, mem_addr_i);
`endif

    assign take_mem = accept && mem_op && !misal;
    // A same-cycle addr_ok/data_ok completes straight from REQ.
    assign finish   = ((state == S_REQ) && data_addr_ok_i && data_data_ok_i) ||
                      ((state == S_WAIT) && data_data_ok_i);

    dmem_lane u_lane (
        .op    (op_q),
        .off   (addr_q[1:0]),
        .sdata (sdata_q),
        .rdata (data_rdata_i),
        .size  (lane_size),
        .wstrb (lane_wstrb),
        .wdata (lane_wdata),
        .ldata (lane_ldata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (take_mem) state_nxt = S_REQ;
            S_REQ:  if (data_addr_ok_i) state_nxt = data_data_ok_i ? S_IDLE : S_WAIT;
            S_WAIT: if (data_data_ok_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ex_ready_o   = (state == S_IDLE);
        data_req_o   = 1'b0;
        data_wr_o    = 1'b0;
        data_size_o  = 2'b00;
        data_wstrb_o = 4'b0000;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;
        if (state == S_REQ) begin
            data_req_o   = 1'b1;
            data_wr_o    = is_store(op_q);
            data_size_o  = lane_size;
            data_wstrb_o = is_store(op_q) ? lane_wstrb : 4'b0000;
            data_addr_o  = addr_q;
            data_wdata_o = is_store(op_q) ? lane_wdata : 32'h0;
        end
    end

    // Transaction capture: datapath only, qualified by the FSM.
    always_ff @(posedge clk) begin
        if (take_mem) begin
            op_q    <= aluop_i;
            addr_q  <= issue_addr;
            sdata_q <= reg2_i;
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_o <= 1'b0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            wdata_o    <= 32'h0;
        end else begin
            wb_valid_o <= 1'b0;
            if (accept && !mem_op) begin
                wb_valid_o <= 1'b1;
                wd_o       <= wd_i;
                wreg_o     <= wreg_i;
                wdata_o    <= wdata_i;
            end else if (accept && misal) begin
                wb_valid_o <= 1'b1;
                wd_o       <= wd_i;
                wreg_o     <= 1'b0;
                wdata_o    <= 32'h0;
            end else if (finish) begin
                wb_valid_o <= 1'b1;
                wd_o       <= wd_q;
                wreg_o     <= wreg_q && is_load(op_q);
                wdata_o    <= is_load(op_q) ? lane_ldata : 32'h0;
            end
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ale_o <= 1'b0;
        else      ale_o <= accept && misal;
    end
`else
    assign ale_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- directed self-checking bench for dmem_ctrl.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        ex_ready_o, data_req_o, data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_addr_ok_i, data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_valid_o, wreg_o, ale_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .aluop_i        (aluop_i),
        .mem_addr_i     (mem_addr_i),
        .reg2_i         (reg2_i),
        .wd_i           (wd_i),
        .wreg_i         (wreg_i),
        .wdata_i        (wdata_i),
        .ex_ready_o     (ex_ready_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .wb_valid_o     (wb_valid_o),
        .wd_o           (wd_o),
        .wreg_o         (wreg_o),
        .wdata_o        (wdata_o),
        .ale_o          (ale_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] r2, input logic [4:0] wd);
        ex_valid_i = 1'b1;
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = r2;
        wd_i       = wd;
        wreg_i     = 1'b1;
        wdata_i    = 32'h0;
    endtask

    task automatic idle_inputs();
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
    endtask

    // Single-cycle load: accept, then addr_ok+data_ok in the REQ cycle.
    task automatic quick_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                              input logic [31:0] rd, input logic [31:0] exp);
        issue(op, addr, 32'h0, 5'd9);
        tick();
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i   = rd;
        tick();
        idle_inputs();
        check({tag, ".wb"}, {31'h0, wb_valid_o}, 32'h1);
        check({tag, ".wdata"}, wdata_o, exp);
    endtask

    initial begin
        rst = 1'b0;
        aluop_i = 8'h0; mem_addr_i = 32'h0; reg2_i = 32'h0; wd_i = 5'd0;
        wreg_i = 1'b0; wdata_i = 32'h0; data_rdata_i = 32'h0;
        idle_inputs();
        tick();
        tick();
        check("rst.ex_ready", {31'h0, ex_ready_o}, 32'h1);
        check("rst.req",      {31'h0, data_req_o}, 32'h0);
        check("rst.wb",       {31'h0, wb_valid_o}, 32'h0);
        check("rst.wdata",    wdata_o, 32'h0);
        check("rst.ale",      {31'h0, ale_o}, 32'h0);
        rst = 1'b1;
        tick();

        // add then ld.w back to back
        issue(ALUOP_ADD, 32'h0, 32'h0, 5'd3);
        wdata_i = 32'h5;
        check("b2b.ready0", {31'h0, ex_ready_o}, 32'h1);
        tick();
        check("b2b.add_wb",    {31'h0, wb_valid_o}, 32'h1);
        check("b2b.add_wdata", wdata_o, 32'h5);
        check("b2b.add_wd",    {27'h0, wd_o}, 32'd3);
        check("b2b.add_wreg",  {31'h0, wreg_o}, 32'h1);
        issue(ALUOP_LD_W, 32'h100, 32'h0, 5'd4);
        check("b2b.ready1", {31'h0, ex_ready_o}, 32'h1);
        tick();
        ex_valid_i = 1'b0;
        check("b2b.req",   {31'h0, data_req_o}, 32'h1);
        check("b2b.addr",  data_addr_o, 32'h100);
        check("b2b.wr",    {31'h0, data_wr_o}, 32'h0);
        check("b2b.wstrb", {28'h0, data_wstrb_o}, 32'h0);
        check("b2b.size",  {30'h0, data_size_o}, 32'd2);
        check("b2b.ready2", {31'h0, ex_ready_o}, 32'h0);
        check("b2b.nowb",  {31'h0, wb_valid_o}, 32'h0);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
        tick();
        idle_inputs();
        check("b2b.ld_wb",    {31'h0, wb_valid_o}, 32'h1);
        check("b2b.ld_wdata", wdata_o, 32'hDEADBEEF);
        check("b2b.ld_wd",    {27'h0, wd_o}, 32'd4);
        check("b2b.ld_wreg",  {31'h0, wreg_o}, 32'h1);
        tick();
        check("b2b.wb_pulse", {31'h0, wb_valid_o}, 32'h0);

        // load extract/extend, including the sign-extended ld.b at lane 3
        quick_load("ldb",  ALUOP_LD_B,  32'h1003, 32'h80000000, 32'hFFFFFF80);
        check("ldb.ready", {31'h0, ex_ready_o}, 32'h1);
        quick_load("ldbu", ALUOP_LD_BU, 32'h0001, 32'h0000A500, 32'h000000A5);
        quick_load("ldh",  ALUOP_LD_H,  32'h0002, 32'h80011234, 32'hFFFF8001);
        quick_load("ldh0", ALUOP_LD_H,  32'h0000, 32'h80011234, 32'h00001234);

        // st.h with addr_ok delayed 3 cycles -> request held 4 cycles
        issue(ALUOP_ST_H, 32'h2002, 32'h1234ABCD, 5'd7);
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("sth.req",   {31'h0, data_req_o}, 32'h1);
            check("sth.addr",  data_addr_o, 32'h2002);
            check("sth.wstrb", {28'h0, data_wstrb_o}, 32'hC);
            check("sth.wdata", data_wdata_o, 32'hABCDABCD);
            check("sth.wr",    {31'h0, data_wr_o}, 32'h1);
            if (i == 3) data_addr_ok_i = 1'b1;
            tick();
        end
        data_addr_ok_i = 1'b0;
        check("sth.req_off", {31'h0, data_req_o}, 32'h0);
        check("sth.wait_rdy", {31'h0, ex_ready_o}, 32'h0);
        data_data_ok_i = 1'b1;
        tick();
        idle_inputs();
        check("sth.wb",   {31'h0, wb_valid_o}, 32'h1);
        check("sth.wreg", {31'h0, wreg_o}, 32'h0);

        // st.b lane 3 and st.w strobes
        issue(ALUOP_ST_B, 32'h0003, 32'h000000EF, 5'd1);
        tick();
        ex_valid_i = 1'b0;
        check("stb.wstrb", {28'h0, data_wstrb_o}, 32'h8);
        check("stb.wdata", data_wdata_o, 32'hEFEFEFEF);
        check("stb.size",  {30'h0, data_size_o}, 32'd0);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1;
        tick();
        idle_inputs();
        issue(ALUOP_ST_W, 32'h0008, 32'h01020304, 5'd1);
        tick();
        ex_valid_i = 1'b0;
        check("stw.wstrb", {28'h0, data_wstrb_o}, 32'hF);
        check("stw.wdata", data_wdata_o, 32'h01020304);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1;
        tick();
        idle_inputs();

        // ld.hu with data_ok 5 cycles after addr_ok
        issue(ALUOP_LD_HU, 32'h0010, 32'h0, 5'd6);
        tick();
        ex_valid_i = 1'b0;
        data_addr_ok_i = 1'b1;
        check("ldhu.ready_req", {31'h0, ex_ready_o}, 32'h0);
        tick();
        data_addr_ok_i = 1'b0;
        data_rdata_i   = 32'h5555F00D;
        for (int i = 0; i < 4; i++) begin
            check("ldhu.ready_wait", {31'h0, ex_ready_o}, 32'h0);
            check("ldhu.nowb", {31'h0, wb_valid_o}, 32'h0);
            tick();
        end
        check("ldhu.ready_last", {31'h0, ex_ready_o}, 32'h0);
        data_data_ok_i = 1'b1;
        tick();
        idle_inputs();
        check("ldhu.wb",    {31'h0, wb_valid_o}, 32'h1);
        check("ldhu.wdata", wdata_o, 32'h0000F00D);

        // stray data_ok while idle is ignored
        data_data_ok_i = 1'b1;
        tick();
        idle_inputs();
        check("stray.wb", {31'h0, wb_valid_o}, 32'h0);
        check("stray.ready", {31'h0, ex_ready_o}, 32'h1);

        // misaligned ld.w
        issue(ALUOP_LD_W, 32'h0006, 32'h0, 5'd2);
        tick();
        ex_valid_i = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        check("ale.req",  {31'h0, data_req_o}, 32'h0);
        check("ale.wb",   {31'h0, wb_valid_o}, 32'h1);
        check("ale.ale",  {31'h0, ale_o}, 32'h1);
        check("ale.wreg", {31'h0, wreg_o}, 32'h0);
        check("ale.ready", {31'h0, ex_ready_o}, 32'h1);
        tick();
        check("ale.pulse", {31'h0, ale_o}, 32'h0);
`else
        check("mis.req",  {31'h0, data_req_o}, 32'h1);
        check("mis.addr", data_addr_o, 32'h0000_0004);
        check("mis.ale",  {31'h0, ale_o}, 32'h0);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h11223344;
        tick();
        idle_inputs();
        check("mis.wdata", wdata_o, 32'h11223344);
        check("mis.ale_wb", {31'h0, ale_o}, 32'h0);
`endif

        // reset during WAIT drops the pending response
        issue(ALUOP_LD_W, 32'h0040, 32'h0, 5'd8);
        tick();
        ex_valid_i = 1'b0;
        data_addr_ok_i = 1'b1;
        tick();
        data_addr_ok_i = 1'b0;
        check("rstw.in_wait", {31'h0, ex_ready_o}, 32'h0);
        rst = 1'b0;
        #1;
        check("rstw.ready", {31'h0, ex_ready_o}, 32'h1);
        check("rstw.req",   {31'h0, data_req_o}, 32'h0);
        check("rstw.wb",    {31'h0, wb_valid_o}, 32'h0);
        tick();
        rst = 1'b1;
        data_data_ok_i = 1'b1;
        data_rdata_i = 32'hCAFEF00D;
        tick();
        idle_inputs();
        check("rstw.no_wb", {31'h0, wb_valid_o}, 32'h0);
        check("rstw.idle",  {31'h0, ex_ready_o}, 32'h1);
        tick();
        check("rstw.no_wb2", {31'h0, wb_valid_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
